mem_access_arbiter: RTL and testbench

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_access_arbiter.sv | 107 ++++++++++
 tb/tb_mem_access_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port word memory.
// Each access runs IDLE -> ACCESS -> DONE; the memory side is driven only from latched state.
module mem_access_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              gnt_a,
   output logic              done_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              gnt_b,
   output logic              done_b,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_ldr_str_en,
   output logic              mem_load_en,
   output logic              mem_store_en,
   input  logic [DATA_W-1:0] mem_read_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t state, state_nxt;
   logic   req_any;
   logic   sel_b;    // winner of the current IDLE sample (1 = b)
   logic   win_b;    // latched winner of the access in flight
   logic   last_b;   // last grant went to b
   logic   lat_we;

   assign req_any = req_a | req_b;
   // On a tie the requester not granted last wins; otherwise the sole requester wins.
   assign sel_b   = (req_a && req_b) ? ~last_b : req_b;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = ACCESS;
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_b         <= 1'b1;
         win_b          <= 1'b0;
         lat_we         <= 1'b0;
         mem_addr       <= '0;
         mem_write_data <= '0;
         rdata          <= '0;
      end else begin
         if (state == IDLE && req_any) begin
            win_b          <= sel_b;
            last_b         <= sel_b;
            lat_we         <= sel_b ? we_b    : we_a;
            mem_addr       <= sel_b ? addr_b  : addr_a;
            mem_write_data <= sel_b ? wdata_b : wdata_a;
         end
         if (state == ACCESS && !lat_we) rdata <= mem_read_data;
      end
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      gnt_a          = 1'b0;
      gnt_b          = 1'b0;
      done_a         = 1'b0;
      done_b         = 1'b0;
      mem_ldr_str_en = 1'b0;
      mem_load_en    = 1'b0;
      mem_store_en   = 1'b0;
      busy           = (state != IDLE);
      case (state)
         ACCESS: begin
            gnt_a          = ~win_b;
            gnt_b          = win_b;
            // Enables are gated by rst so a reset landing in ACCESS never reaches memory.
            mem_ldr_str_en = ~rst;
            mem_store_en   = lat_we & ~rst;
            mem_load_en    = ~lat_we & ~rst;
         end
         DONE: begin
            done_a = ~win_b & ~rst;
            done_b = win_b & ~rst;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench: constant vector table, hand-written corner sequences and a
// randomized run, all compared against a transaction-phase reference model.
module tb_mem_access_arbiter;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_a, we_a, req_b, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic          gnt_a, gnt_b, done_a, done_b, busy;
   logic [DW-1:0] rdata, mem_write_data, mem_read_data;
   logic [AW-1:0] mem_addr;
   logic          mem_ldr_str_en, mem_load_en, mem_store_en;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
      .gnt_a(gnt_a), .done_a(done_a),
      .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
      .gnt_b(gnt_b), .done_b(done_b),
      .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_ldr_str_en(mem_ldr_str_en), .mem_load_en(mem_load_en),
      .mem_store_en(mem_store_en), .mem_read_data(mem_read_data)
   );

   // Memory attached to the DUT.
   logic [DW-1:0] mem [16] = '{default: '0};
   always @(posedge clk) if (mem_store_en) mem[mem_addr] <= mem_write_data;
   assign mem_read_data = mem[mem_addr];

   // Reference model: phase 0 = idle, 1 = access in flight, 2 = completion cycle.
   logic [DW-1:0] ref_mem [16] = '{default: '0};
   int            m_phase = 0;
   int            m_who   = 0;   // 0 = a, 1 = b
   int            m_last  = 1;
   logic          m_we    = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rdata = '0;

   task automatic model_edge();
      int w;
      if (rst) begin
         m_phase = 0; m_last = 1; m_who = 0; m_we = 1'b0;
         m_addr = '0; m_wdata = '0; m_rdata = '0;
      end else if (m_phase == 0) begin
         if (req_a || req_b) begin
            if (req_a && req_b) w = 1 - m_last;
            else                w = req_a ? 0 : 1;
            m_who   = w;
            m_last  = w;
            m_we    = (w == 1) ? we_b    : we_a;
            m_addr  = (w == 1) ? addr_b  : addr_a;
            m_wdata = (w == 1) ? wdata_b : wdata_a;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (m_we) ref_mem[m_addr] = m_wdata;
         else      m_rdata = ref_mem[m_addr];
         m_phase = 2;
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic compare_model();
      logic acc, dn;
      acc = (m_phase == 1);
      dn  = (m_phase == 2);
      check("gnt_a",   64'(gnt_a),  64'(acc && m_who == 0));
      check("gnt_b",   64'(gnt_b),  64'(acc && m_who == 1));
      check("done_a",  64'(done_a), 64'(dn && m_who == 0 && !rst));
      check("done_b",  64'(done_b), 64'(dn && m_who == 1 && !rst));
      check("busy",    64'(busy),   64'(m_phase != 0));
      check("ldr_str", 64'(mem_ldr_str_en), 64'(acc && !rst));
      check("store",   64'(mem_store_en),   64'(acc && m_we && !rst));
      check("load",    64'(mem_load_en),    64'(acc && !m_we && !rst));
      check("mem_addr",  64'(mem_addr),       64'(m_addr));
      check("mem_wdata", 64'(mem_write_data), 64'(m_wdata));
      check("rdata",     64'(rdata),          64'(m_rdata));
   endtask

   // One clock: model advances on the edge, outputs compared on the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_model();
   endtask

   task automatic drive(input logic r, input logic ra, input logic wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic rb, input logic wb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db);
      rst = r; req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
      req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
   endtask

   typedef struct {
      logic          rst, req_a, we_a;
      logic [AW-1:0] addr_a;
      logic [DW-1:0] wdata_a;
      logic          req_b, we_b;
      logic [AW-1:0] addr_b;
      logic [DW-1:0] wdata_b;
      logic          e_gnt_a, e_gnt_b, e_done_a, e_done_b, e_store, e_load;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_rdata;
   } vec_t;

   vec_t tv [12];

   initial begin
      logic [DW-1:0] word7;

      // Expected outputs are those seen in the cycle after the vector's inputs are sampled.
      tv[0]  = '{1,0,0,0,0,          0,0,0,0,    0,0,0,0,0,0, 0, 0};
      tv[1]  = '{0,1,1,3,32'hDEADBEEF, 0,0,0,0,  1,0,0,0,1,0, 3, 0};
      tv[2]  = '{0,0,0,0,0,          0,0,0,0,    0,0,1,0,0,0, 3, 0};
      tv[3]  = '{0,0,0,0,0,          0,0,0,0,    0,0,0,0,0,0, 3, 0};
      tv[4]  = '{0,0,0,0,0,          1,0,3,0,    0,1,0,0,0,1, 3, 0};
      tv[5]  = '{0,0,0,0,0,          0,0,0,0,    0,0,0,1,0,0, 3, 32'hDEADBEEF};
      tv[6]  = '{0,0,0,0,0,          0,0,0,0,    0,0,0,0,0,0, 3, 32'hDEADBEEF};
      tv[7]  = '{0,1,0,1,0,          1,1,2,32'h55, 1,0,0,0,0,1, 1, 32'hDEADBEEF};
      tv[8]  = '{0,1,0,1,0,          1,1,2,32'h55, 0,0,1,0,0,0, 1, 0};
      tv[9]  = '{0,1,0,1,0,          1,1,2,32'h55, 0,0,0,0,0,0, 1, 0};
      tv[10] = '{0,1,0,1,0,          1,1,2,32'h55, 0,1,0,0,1,0, 2, 0};
      tv[11] = '{0,1,0,1,0,          1,1,2,32'h55, 0,0,0,1,0,0, 2, 0};

      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         drive(tv[i].rst, tv[i].req_a, tv[i].we_a, tv[i].addr_a, tv[i].wdata_a,
               tv[i].req_b, tv[i].we_b, tv[i].addr_b, tv[i].wdata_b);
         step();
         check($sformatf("tv%0d.gnt_a", i),  64'(gnt_a),        64'(tv[i].e_gnt_a));
         check($sformatf("tv%0d.gnt_b", i),  64'(gnt_b),        64'(tv[i].e_gnt_b));
         check($sformatf("tv%0d.done_a", i), 64'(done_a),       64'(tv[i].e_done_a));
         check($sformatf("tv%0d.done_b", i), 64'(done_b),       64'(tv[i].e_done_b));
         check($sformatf("tv%0d.store", i),  64'(mem_store_en), 64'(tv[i].e_store));
         check($sformatf("tv%0d.load", i),   64'(mem_load_en),  64'(tv[i].e_load));
         check($sformatf("tv%0d.addr", i),   64'(mem_addr),     64'(tv[i].e_addr));
         check($sformatf("tv%0d.rdata", i),  64'(rdata),        64'(tv[i].e_rdata));
      end
      check("tv.mem3", 64'(mem[3]), 64'(32'hDEADBEEF));
      check("tv.mem2", 64'(mem[2]), 64'(32'h55));

      // Reset, then both requesters held: grants must go a, b, a, b.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 1, 0, 4, 0, 1, 0, 6, 0);
      for (int c = 0; c < 12; c++) begin
         step();
         check("tie.one_gnt", 64'(gnt_a & gnt_b), 64'(0));
         if (c % 3 == 0) check("tie.order", 64'(gnt_b), 64'((c / 3) % 2));
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); step(); step();

      // Address change while the access is in flight must not reach memory.
      drive(0, 1, 0, 5, 0, 0, 0, 0, 0);
      step();
      addr_a = 9;
      check("hold.acc_addr", 64'(mem_addr), 64'(5));
      step();
      check("hold.done_addr", 64'(mem_addr), 64'(5));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();

      // Reset landing in the ACCESS cycle of a store to word 7.
      word7 = ref_mem[7];
      drive(0, 1, 1, 7, 32'h12345678, 0, 0, 0, 0);
      step();
      rst = 1; req_a = 0;
      #1;
      check("rst_acc.store_en", 64'(mem_store_en), 64'(0));
      compare_model();
      step();
      check("rst_acc.done_a", 64'(done_a), 64'(0));
      check("rst_acc.addr",   64'(mem_addr), 64'(0));
      check("rst_acc.busy",   64'(busy), 64'(0));
      check("rst_acc.mem7",   64'(mem[7]), 64'(word7));
      drive(0, 1, 0, 1, 0, 1, 0, 2, 0);
      step();
      check("rst_acc.tie_a", 64'(gnt_a), 64'(1));
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(); step();

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
               AW'($urandom), $urandom, $urandom_range(0, 2) != 0, 1'($urandom),
               AW'($urandom), $urandom);
         step();
      end
      for (int k = 0; k < 16; k++) check($sformatf("mem%0d", k), 64'(mem[k]), 64'(ref_mem[k]));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
